// File: rtl/bsg_rocket_pkg.sv
// Shared NASTI tunnel types, packet defaults and decoder FSM encoding.
package bsg_rocket_pkg;

    localparam int unsigned NastiAddrWidth = 32;
    localparam int unsigned NastiIdWidth   = 5;
    localparam int unsigned NastiDataWidth = 32;
    localparam int unsigned NastiStrbWidth = NastiDataWidth / 8;

    typedef struct packed {
        logic [NastiAddrWidth-1:0] addr;
        logic [NastiIdWidth-1:0]   id;
        logic                      rw;
    } bsg_nasti_sa_pkt;

    localparam int unsigned TunWidth = $bits(bsg_nasti_sa_pkt);

    typedef logic [TunWidth-1:0] bsg_tun_dmx_t;

    // Data words share the tunnel width with address words; upper bits are padding.
    typedef struct packed {
        logic [TunWidth-NastiDataWidth-2:0] pad;
        logic [NastiDataWidth-1:0]          data;
        logic                               last;
    } bsg_nasti_sw_pkt;

    typedef struct packed {
        logic [NastiAddrWidth-1:0] addr;
        logic [7:0]                len;
        logic [2:0]                size;
        logic [1:0]                burst;
        logic [NastiIdWidth-1:0]   id;
    } bsg_nasti_a_pkt;

    typedef struct packed {
        logic [NastiDataWidth-1:0] data;
        logic [NastiStrbWidth-1:0] strb;
        logic                      last;
    } bsg_nasti_w_pkt;

    typedef struct packed {
        logic [NastiIdWidth-1:0] id;
        logic [1:0]              resp;
    } bsg_nasti_b_pkt;

    localparam logic [7:0]                NastiLenDefault   = 8'd0;
    localparam logic [2:0]                NastiSizeDefault  = 3'd2;
    localparam logic [1:0]                NastiBurstDefault = 2'b01;
    localparam logic [NastiStrbWidth-1:0] NastiStrbDefault  = '1;

    typedef enum logic [5:0] {
        StIdle  = 6'b000001,
        StRaddr = 6'b000010,
        StWaddr = 6'b000100,
        StWwait = 6'b001000,
        StWdata = 6'b010000,
        StWresp = 6'b100000
    } req_state_e;

    function automatic bsg_nasti_a_pkt make_a_pkt(input bsg_nasti_sa_pkt sa);
        bsg_nasti_a_pkt p;
        p.addr  = sa.addr;
        p.len   = NastiLenDefault;
        p.size  = NastiSizeDefault;
        p.burst = NastiBurstDefault;
        p.id    = sa.id;
        return p;
    endfunction

endpackage

// File: rtl/bsg_nasti_master_req.sv
// Decodes tunnelled NASTI request words into AR / AW / W transactions and sinks B responses,
// counting non-OKAY responses with a saturating counter.
module bsg_nasti_master_req
    import bsg_rocket_pkg::*;
#(
    parameter int unsigned err_cnt_width_p = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       req_valid_i,
    input  bsg_tun_dmx_t               req_data_i,
    output logic                       req_yumi_o,
    output logic                       nasti_ar_valid_o,
    output bsg_nasti_a_pkt             nasti_ar_data_o,
    input  logic                       nasti_ar_ready_i,
    output logic                       nasti_aw_valid_o,
    output bsg_nasti_a_pkt             nasti_aw_data_o,
    input  logic                       nasti_aw_ready_i,
    output logic                       nasti_w_valid_o,
    output bsg_nasti_w_pkt             nasti_w_data_o,
    input  logic                       nasti_w_ready_i,
    input  logic                       nasti_b_valid_i,
    input  bsg_nasti_b_pkt             nasti_b_data_i,
    output logic                       nasti_b_ready_o,
    output logic [err_cnt_width_p-1:0] b_err_cnt_o
);

    req_state_e                 state_q, state_d;
    bsg_tun_dmx_t               data_q, data_d;
    logic [err_cnt_width_p-1:0] cnt_q, cnt_d;
    logic                       yumi;
    logic                       b_accept;
    bsg_nasti_sa_pkt            req_sa, hold_sa;
    bsg_nasti_sw_pkt            hold_sw;
    logic                       unused_fields;

    assign req_sa  = bsg_nasti_sa_pkt'(req_data_i);
    assign hold_sa = bsg_nasti_sa_pkt'(data_q);
    assign hold_sw = bsg_nasti_sw_pkt'(data_q);

    assign nasti_ar_data_o = make_a_pkt(hold_sa);
    assign nasti_aw_data_o = make_a_pkt(hold_sa);
    assign nasti_w_data_o  = '{data: hold_sw.data, strb: NastiStrbDefault, last: hold_sw.last};

    // Direction is taken from the incoming word so the branch lands in the same cycle as the latch.
    assign unused_fields = ^{req_sa.addr, req_sa.id, hold_sa.rw, hold_sw.pad, nasti_b_data_i.id};

    always_comb begin
        state_d          = state_q;
        data_d           = data_q;
        yumi             = 1'b0;
        nasti_ar_valid_o = 1'b0;
        nasti_aw_valid_o = 1'b0;
        nasti_w_valid_o  = 1'b0;
        nasti_b_ready_o  = 1'b0;
        unique case (state_q)
            StIdle: begin
                yumi = req_valid_i;
                if (req_valid_i) begin
                    data_d  = req_data_i;
                    state_d = req_sa.rw ? StWaddr : StRaddr;
                end
            end
            StRaddr: begin
                nasti_ar_valid_o = 1'b1;
                if (nasti_ar_ready_i) state_d = StIdle;
            end
            StWaddr: begin
                nasti_aw_valid_o = 1'b1;
                if (nasti_aw_ready_i) state_d = StWwait;
            end
            StWwait: begin
                yumi = req_valid_i;
                if (req_valid_i) begin
                    data_d  = req_data_i;
                    state_d = StWdata;
                end
            end
            StWdata: begin
                nasti_w_valid_o = 1'b1;
                if (nasti_w_ready_i) state_d = hold_sw.last ? StWresp : StWwait;
            end
            StWresp: begin
                nasti_b_ready_o = 1'b1;
                if (nasti_b_valid_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // The idle state would otherwise echo req_valid_i while reset is held.
    assign req_yumi_o = yumi & reset_n_i;

    assign b_accept = nasti_b_valid_i & nasti_b_ready_o;

    always_comb begin
        cnt_d = cnt_q;
        if (b_accept && (nasti_b_data_i.resp != 2'b00) && (cnt_q != '1)) begin
            cnt_d = cnt_q + {{(err_cnt_width_p-1){1'b0}}, 1'b1};
        end
    end

    assign b_err_cnt_o = cnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= StIdle;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
